scalar_writeback_queue: RTL and testbench

SCALAR_WRITEBACK_QUEUE -- requirements
Module: scalar_writeback_queue

---
 rtl/scalar_writeback_queue.sv | 110 +++++++++++
 tb/tb_scalar_writeback_queue.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/scalar_writeback_queue.sv
// Four-entry writeback queue merging load-unit and ALU results into one
// register-file write port, with pending-write lookup for the decode stage.
module scalar_writeback_queue (
    input  logic        clk,
    input  logic        rst,
    input  logic        AluValid,
    input  logic [4:0]  AluRd,
    input  logic [31:0] AluData,
    output logic        AluReady,
    input  logic        MemValid,
    input  logic [4:0]  MemRd,
    input  logic [31:0] MemData,
    output logic        MemReady,
    output logic        WriteEn,
    output logic [4:0]  rd,
    output logic [31:0] InputData,
    input  logic [4:0]  Rs1,
    input  logic [4:0]  Rs2,
    output logic        Pending1,
    output logic        Pending2,
    output logic        DropErr
);

    logic [4:0]  ent_rd   [4];
    logic [31:0] ent_data [4];
    logic [1:0]  wptr;
    logic [1:0]  rptr;
    logic [2:0]  count;
    logic        drop_q;

    logic        mem_acc;
    logic        alu_acc;
    logic        mem_keep;
    logic        alu_keep;
    logic        drop_next;
    logic        pop;
    logic [1:0]  alu_wptr;
    logic [2:0]  count_next;

    // Readiness looks only at the registered count; the same-cycle pop earns no credit.
    always_comb begin
        MemReady = (count <= 3'd3) && !rst;
        AluReady = (((count <= 3'd3) && !MemValid) || (count <= 3'd2)) && !rst;
    end

    always_comb begin
        mem_acc    = MemValid && MemReady;
        alu_acc    = AluValid && AluReady;
        // x0 writes vanish silently; x16..x31 vanish and raise DropErr.
        mem_keep   = mem_acc && (MemRd != 5'd0) && !MemRd[4];
        alu_keep   = alu_acc && (AluRd != 5'd0) && !AluRd[4];
        drop_next  = (mem_acc && MemRd[4]) || (alu_acc && AluRd[4]);
        pop        = (count != 3'd0);
        alu_wptr   = wptr + {1'b0, mem_keep};
        count_next = count + {2'b00, mem_keep} + {2'b00, alu_keep} - {2'b00, pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                ent_rd[i]   <= 5'd0;
                ent_data[i] <= 32'd0;
            end
            wptr   <= 2'd0;
            rptr   <= 2'd0;
            count  <= 3'd0;
            drop_q <= 1'b0;
        end else begin
            if (mem_keep) begin
                ent_rd[wptr]   <= MemRd;
                ent_data[wptr] <= MemData;
            end
            if (alu_keep) begin
                ent_rd[alu_wptr]   <= AluRd;
                ent_data[alu_wptr] <= AluData;
            end
            wptr   <= wptr + {1'b0, mem_keep} + {1'b0, alu_keep};
            rptr   <= rptr + {1'b0, pop};
            count  <= count_next;
            drop_q <= drop_next;
        end
    end

    always_comb begin
        WriteEn   = (count != 3'd0);
        rd        = WriteEn ? ent_rd[rptr]   : 5'd0;
        InputData = WriteEn ? ent_data[rptr] : 32'd0;
        DropErr   = drop_q;
    end

    // Walk the occupied slots starting at the head.
    logic [1:0] idx;
    logic       hit1;
    logic       hit2;
    always_comb begin
        idx  = 2'd0;
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = rptr + 2'(i);
            if (3'(i) < count) begin
                if (ent_rd[idx] == Rs1) hit1 = 1'b1;
                if (ent_rd[idx] == Rs2) hit2 = 1'b1;
            end
        end
        Pending1 = hit1 && (Rs1 != 5'd0);
        Pending2 = hit2 && (Rs2 != 5'd0);
    end

endmodule

// File: tb/tb_scalar_writeback_queue.sv
// Bench for scalar_writeback_queue: directed vector table, then randomized
// traffic checked against a queue-based reference model.
module tb_scalar_writeback_queue;

    logic        clk;
    logic        rst;
    logic        AluValid;
    logic [4:0]  AluRd;
    logic [31:0] AluData;
    logic        AluReady;
    logic        MemValid;
    logic [4:0]  MemRd;
    logic [31:0] MemData;
    logic        MemReady;
    logic        WriteEn;
    logic [4:0]  rd;
    logic [31:0] InputData;
    logic [4:0]  Rs1;
    logic [4:0]  Rs2;
    logic        Pending1;
    logic        Pending2;
    logic        DropErr;

    scalar_writeback_queue dut (
        .clk(clk), .rst(rst),
        .AluValid(AluValid), .AluRd(AluRd), .AluData(AluData), .AluReady(AluReady),
        .MemValid(MemValid), .MemRd(MemRd), .MemData(MemData), .MemReady(MemReady),
        .WriteEn(WriteEn), .rd(rd), .InputData(InputData),
        .Rs1(Rs1), .Rs2(Rs2), .Pending1(Pending1), .Pending2(Pending2),
        .DropErr(DropErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: queued {rd, data} in commit order.
    logic [36:0] q[$];
    logic        exp_drop = 1'b0;

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        ar;
        logic        mr;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        p1;
        logic        p2;
        logic        drop;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                         input logic [4:0] s1, input logic [4:0] s2);
        rst = r; AluValid = av; AluRd = ard; AluData = ad;
        MemValid = mv; MemRd = mrd; MemData = md; Rs1 = s1; Rs2 = s2;
    endtask

    function automatic logic model_mem_ready();
        return (q.size() <= 3) && !rst;
    endfunction

    function automatic logic model_alu_ready();
        return (((q.size() <= 3) && !MemValid) || (q.size() <= 2)) && !rst;
    endfunction

    function automatic logic model_pending(input logic [4:0] s);
        if (s == 5'd0) return 1'b0;
        foreach (q[i]) if (q[i][36:32] == s) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_model();
        chk("mem_ready", {31'd0, MemReady}, {31'd0, model_mem_ready()});
        chk("alu_ready", {31'd0, AluReady}, {31'd0, model_alu_ready()});
        chk("write_en", {31'd0, WriteEn}, {31'd0, q.size() != 0});
        chk("rd", {27'd0, rd}, q.size() != 0 ? {27'd0, q[0][36:32]} : 32'd0);
        chk("data", InputData, q.size() != 0 ? q[0][31:0] : 32'd0);
        chk("pending1", {31'd0, Pending1}, {31'd0, model_pending(Rs1)});
        chk("pending2", {31'd0, Pending2}, {31'd0, model_pending(Rs2)});
        chk("drop_err", {31'd0, DropErr}, {31'd0, exp_drop});
    endtask

    // Advance the model across the coming clock edge using the applied inputs.
    task automatic model_step();
        logic macc;
        logic aacc;
        if (rst) begin
            q.delete();
            exp_drop = 1'b0;
        end else begin
            macc = MemValid && model_mem_ready();
            aacc = AluValid && model_alu_ready();
            if (q.size() != 0) void'(q.pop_front());
            if (macc && MemRd != 5'd0 && MemRd < 5'd16) q.push_back({MemRd, MemData});
            if (aacc && AluRd != 5'd0 && AluRd < 5'd16) q.push_back({AluRd, AluData});
            exp_drop = (macc && MemRd >= 5'd16) || (aacc && AluRd >= 5'd16);
            chk("occupancy_le_4", {31'd0, q.size() <= 4}, 32'd1);
        end
    endtask

    function automatic logic [4:0] pick_rd();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 5'd0;
        if (r == 1) return 5'(16 + $urandom_range(0, 15));
        return 5'($urandom_range(1, 7));
    endfunction

    initial begin
        //            rst av ard   ad            mv mrd   md            rs1   rs2   ar mr we rd    data          p1 p2 dr
        vecs[0]  = '{1, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        5'd0, 5'd0, 0, 0, 0, 5'd0, 32'h0,        0, 0, 0};
        vecs[1]  = '{0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        5'd0, 5'd0, 1, 1, 0, 5'd0, 32'h0,        0, 0, 0};
        vecs[2]  = '{0, 1, 5'd3,  32'hDEADBEEF, 0, 5'd0,  32'h0,        5'd3, 5'd0, 1, 1, 0, 5'd0, 32'h0,        0, 0, 0};
        vecs[3]  = '{0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        5'd3, 5'd0, 1, 1, 1, 5'd3, 32'hDEADBEEF, 1, 0, 0};
        vecs[4]  = '{0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        5'd3, 5'd0, 1, 1, 0, 5'd0, 32'h0,        0, 0, 0};
        vecs[5]  = '{0, 1, 5'd6,  32'h22,       1, 5'd5,  32'h11,       5'd6, 5'd5, 1, 1, 0, 5'd0, 32'h0,        0, 0, 0};
        vecs[6]  = '{0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        5'd6, 5'd5, 1, 1, 1, 5'd5, 32'h11,       1, 1, 0};
        vecs[7]  = '{0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        5'd6, 5'd5, 1, 1, 1, 5'd6, 32'h22,       1, 0, 0};
        vecs[8]  = '{0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        5'd6, 5'd5, 1, 1, 0, 5'd0, 32'h0,        0, 0, 0};
        vecs[9]  = '{0, 1, 5'd0,  32'h55,       0, 5'd0,  32'h0,        5'd0, 5'd0, 1, 1, 0, 5'd0, 32'h0,        0, 0, 0};
        vecs[10] = '{0, 1, 5'd20, 32'h66,       0, 5'd0,  32'h0,        5'd0, 5'd0, 1, 1, 0, 5'd0, 32'h0,        0, 0, 0};
        vecs[11] = '{0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        5'd0, 5'd20,1, 1, 0, 5'd0, 32'h0,        0, 0, 1};
        vecs[12] = '{0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        5'd0, 5'd0, 1, 1, 0, 5'd0, 32'h0,        0, 0, 0};
        vecs[13] = '{0, 1, 5'd8,  32'h80,       1, 5'd7,  32'h70,       5'd0, 5'd0, 1, 1, 0, 5'd0, 32'h0,        0, 0, 0};
        vecs[14] = '{0, 1, 5'd10, 32'hA0,       1, 5'd9,  32'h90,       5'd10,5'd8, 1, 1, 1, 5'd7, 32'h70,       0, 1, 0};
        vecs[15] = '{0, 1, 5'd11, 32'hB0,       1, 5'd0,  32'h0,        5'd11,5'd9, 0, 1, 1, 5'd8, 32'h80,       0, 1, 0};
        vecs[16] = '{0, 1, 5'd12, 32'hC0,       1, 5'd13, 32'hD0,       5'd10,5'd11,1, 1, 1, 5'd9, 32'h90,       1, 0, 0};
        vecs[17] = '{1, 1, 5'd5,  32'h50,       1, 5'd4,  32'h40,       5'd12,5'd13,0, 0, 1, 5'd10,32'hA0,       1, 1, 0};
        vecs[18] = '{0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        5'd12,5'd13,1, 1, 0, 5'd0, 32'h0,        0, 0, 0};
        vecs[19] = '{0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        5'd5, 5'd4, 1, 1, 0, 5'd0, 32'h0,        0, 0, 0};

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        q.delete();
        exp_drop = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].av, vecs[i].ard, vecs[i].ad,
                  vecs[i].mv, vecs[i].mrd, vecs[i].md, vecs[i].rs1, vecs[i].rs2);
            #1;
            chk($sformatf("v%0d_alu_ready", i), {31'd0, AluReady}, {31'd0, vecs[i].ar});
            chk($sformatf("v%0d_mem_ready", i), {31'd0, MemReady}, {31'd0, vecs[i].mr});
            chk($sformatf("v%0d_write_en", i), {31'd0, WriteEn}, {31'd0, vecs[i].we});
            chk($sformatf("v%0d_rd", i), {27'd0, rd}, {27'd0, vecs[i].rd});
            chk($sformatf("v%0d_data", i), InputData, vecs[i].data);
            chk($sformatf("v%0d_pending1", i), {31'd0, Pending1}, {31'd0, vecs[i].p1});
            chk($sformatf("v%0d_pending2", i), {31'd0, Pending2}, {31'd0, vecs[i].p2});
            chk($sformatf("v%0d_drop_err", i), {31'd0, DropErr}, {31'd0, vecs[i].drop});
            model_step();
        end

        // Both producers held valid continuously: occupancy, order and wrap.
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            drive(0, 1, 5'($urandom_range(1, 15)), $urandom, 1, 5'($urandom_range(1, 15)), $urandom,
                  5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
            #1;
            check_model();
            model_step();
        end

        // Mixed random traffic with occasional resets.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0, pick_rd(), $urandom,
                  $urandom_range(0, 2) != 0, pick_rd(), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            #1;
            check_model();
            model_step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
